// File: rtl/pattern_pkg.sv
`default_nettype none
// pattern_pkg: shared defaults and elaboration-time helpers for pattern_detector.
package pattern_pkg;

  localparam int         DEF_PLEN    = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1101;

  function automatic int state_width(input int plen);
    return (plen <= 2) ? 1 : $clog2(plen);
  endfunction

  // Next state from state k on bit b: longest pattern prefix (shorter than the
  // whole pattern) that is a suffix of the k matched prefix bits followed by b.
  function automatic int kmp_next(input logic [15:0] pat, input int plen,
                                  input int k, input logic b);
    int   maxj;
    int   t;
    int   result;
    logic ok;
    logic hb;
    result = 0;
    maxj   = (k + 1 < plen - 1) ? k + 1 : plen - 1;
    for (int j = maxj; j >= 1; j--) begin
      if (result == 0) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++) begin
          t  = k + 1 - j + m;
          hb = (t < k) ? pat[plen-1-t] : b;
          if (hb != pat[plen-1-m]) ok = 1'b0;
        end
        if (ok) result = j;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_detector.sv
`default_nettype none
// pattern_detector: serial sequence detector, one-cycle registered pulse per match.
// Rev 1.0 - initial release.
module pattern_detector
  import pattern_pkg::*;
#(
  parameter int             PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
  parameter bit             OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic o
);

  localparam int          SW    = state_width(PLEN);
  localparam int          NS    = 2 ** SW;
  localparam logic [15:0] PAT16 = 16'(PATTERN);

  typedef logic [SW-1:0] state_t;

  state_t state;
  state_t next_state;
  logic   match;
  state_t nxt0 [NS];
  state_t nxt1 [NS];

  // Unused encodings take the transitions of S0.
  generate
    for (genvar k = 0; k < NS; k++) begin : g_state
      localparam int KE = (k < PLEN) ? k : 0;
      localparam int N0 = kmp_next(PAT16, PLEN, KE, 1'b0);
      localparam int N1 = kmp_next(PAT16, PLEN, KE, 1'b1);
      assign nxt0[k] = SW'(N0);
      assign nxt1[k] = SW'(N1);
    end
  endgenerate

  always_comb begin
    match      = (state == SW'(PLEN - 1)) && (i == PATTERN[0]);
    next_state = i ? nxt1[state] : nxt0[state];
    if (match && !OVERLAP) next_state = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      o     <= 1'b0;
    end else begin
      state <= next_state;
      o     <= match;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_detector.sv
`default_nettype none
// tb_pattern_detector: directed vectors on overlapping and non-overlapping instances.
module tb_pattern_detector;

  logic clk;
  logic rst;
  logic i;
  logic o_ov;
  logic o_no;
  int   n_tests;
  int   n_fail;

  pattern_detector #(.PLEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) dut_ov (
    .clk(clk), .rst(rst), .i(i), .o(o_ov)
  );

  pattern_detector #(.PLEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) dut_no (
    .clk(clk), .rst(rst), .i(i), .o(o_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst = 1'b1;
      i   = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("%s_rst_ov[%0d]", tag, c), o_ov, 1'b0);
      check($sformatf("%s_rst_no[%0d]", tag, c), o_no, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input string tag, input logic b, input logic e_ov, input logic e_no);
    @(negedge clk);
    i = b;
    @(posedge clk);
    #1;
    check({tag, "_ov"}, o_ov, e_ov);
    check({tag, "_no"}, o_no, e_no);
  endtask

  // Bits are listed MSB first: bit t of the stream is bits[n-1-t].
  task automatic run_vec(input string name, input int n, input logic [31:0] bits,
                         input logic [31:0] e_ov, input logic [31:0] e_no);
    do_reset(name, 1);
    for (int t = 0; t < n; t++) begin
      send($sformatf("%s[%0d]", name, t), bits[n-1-t], e_ov[n-1-t], e_no[n-1-t]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    i       = 1'b0;

    do_reset("init", 2);
    send("basic[0]", 1'b1, 1'b0, 1'b0);
    send("basic[1]", 1'b1, 1'b0, 1'b0);
    send("basic[2]", 1'b0, 1'b0, 1'b0);
    send("basic[3]", 1'b1, 1'b1, 1'b1);
    send("basic[4]", 1'b0, 1'b0, 1'b0);

    run_vec("overlap",  7, 32'b1101101,  32'b0001001,  32'b0001000);
    run_vec("fb_hold",  5, 32'b11101,    32'b00001,    32'b00001);
    run_vec("fb_drop",  8, 32'b11001101, 32'b00000001, 32'b00000001);
    run_vec("periodic", 20, 32'b11010110101101011010,
                            32'b00010000100001000010,
                            32'b00010000100001000010);
    run_vec("no_ov2",   8, 32'b11011101, 32'b00010001, 32'b00010001);

    do_reset("mid", 1);
    send("mid_a[0]", 1'b1, 1'b0, 1'b0);
    send("mid_a[1]", 1'b1, 1'b0, 1'b0);
    send("mid_a[2]", 1'b0, 1'b0, 1'b0);
    do_reset("mid_b", 1);
    send("mid_c[0]", 1'b1, 1'b0, 1'b0);
    send("mid_c[1]", 1'b1, 1'b0, 1'b0);
    send("mid_c[2]", 1'b0, 1'b0, 1'b0);
    send("mid_c[3]", 1'b1, 1'b1, 1'b1);
    send("mid_c[4]", 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
